// File: rtl/vigna_axil_bridge.sv
// Vigna simple-interface port to AXI4-Lite master bridge with configurable widths,
// bus-error capture and a per-transaction timeout watchdog.
module vigna_axil_bridge #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [2:0]  PROT     = 3'b000,
  parameter int          TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = '1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t              r_state, w_stateNxt;
  logic [ADDR_W-1:0]   r_addr, w_addrNxt;
  logic [DATA_W-1:0]   r_wdata, w_wdataNxt;
  logic [STRB_W-1:0]   r_wstrb, w_wstrbNxt;
  logic                r_arvalid, w_arvalidNxt;
  logic                r_awvalid, w_awvalidNxt;
  logic                r_wvalid, w_wvalidNxt;
  logic                r_sReady, w_sReadyNxt;
  logic [DATA_W-1:0]   r_sRdata, w_sRdataNxt;
  logic                r_errValid, w_errValidNxt;
  logic [1:0]          r_errCode, w_errCodeNxt;
  logic [ADDR_W-1:0]   r_errAddr, w_errAddrNxt;
  logic [CNT_W-1:0]    r_count, w_countNxt;
  logic                w_busy;
  logic                w_timeout;

  // Error responses (resp[1] set) map SLVERR to 01 and DECERR to 10, leaving 11 for timeout.
  function automatic logic [1:0] respToCode(input logic [1:0] resp);
    return resp[0] ? 2'b10 : 2'b01;
  endfunction

  assign w_busy = (r_state == RD_ADDR) || (r_state == RD_DATA) ||
                  (r_state == WR_REQ)  || (r_state == WR_RESP);
  assign w_timeout = (TIMEOUT != 0) && w_busy && (r_count == TO_LAST);

  always_comb begin
    w_stateNxt    = r_state;
    w_addrNxt     = r_addr;
    w_wdataNxt    = r_wdata;
    w_wstrbNxt    = r_wstrb;
    w_arvalidNxt  = r_arvalid;
    w_awvalidNxt  = r_awvalid;
    w_wvalidNxt   = r_wvalid;
    w_sReadyNxt   = r_sReady;
    w_sRdataNxt   = r_sRdata;
    w_errValidNxt = 1'b0;
    w_errCodeNxt  = r_errCode;
    w_errAddrNxt  = r_errAddr;
    w_countNxt    = r_count;

    case (r_state)
      IDLE: begin
        if (s_valid && !r_sReady) begin
          w_addrNxt  = s_addr;
          w_wdataNxt = s_wdata;
          w_wstrbNxt = s_wstrb;
          w_countNxt = '0;
          if (s_wstrb == '0) begin
            w_arvalidNxt = 1'b1;
            w_stateNxt   = RD_ADDR;
          end else begin
            w_awvalidNxt = 1'b1;
            w_wvalidNxt  = 1'b1;
            w_stateNxt   = WR_REQ;
          end
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          w_arvalidNxt = 1'b0;
          w_stateNxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          w_sReadyNxt = 1'b1;
          w_stateNxt  = DONE;
          if (m_rresp[1]) begin
            w_sRdataNxt   = ERR_DATA;
            w_errValidNxt = 1'b1;
            w_errCodeNxt  = respToCode(m_rresp);
            w_errAddrNxt  = r_addr;
          end else begin
            w_sRdataNxt = m_rdata;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on once neither is still outstanding.
        if (m_awready) w_awvalidNxt = 1'b0;
        if (m_wready)  w_wvalidNxt  = 1'b0;
        if ((!r_awvalid || m_awready) && (!r_wvalid || m_wready)) begin
          w_stateNxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          w_sReadyNxt = 1'b1;
          w_stateNxt  = DONE;
          if (m_bresp[1]) begin
            w_errValidNxt = 1'b1;
            w_errCodeNxt  = respToCode(m_bresp);
            w_errAddrNxt  = r_addr;
          end
        end
      end
      DONE: begin
        if (!s_valid) begin
          w_sReadyNxt = 1'b0;
          w_stateNxt  = IDLE;
        end
      end
      default: w_stateNxt = IDLE;
    endcase

    if (w_busy) begin
      w_countNxt = r_count + CNT_W'(1);
    end

    // A hung slave is abandoned; any late response it produces is ignored.
    if (w_timeout) begin
      w_arvalidNxt  = 1'b0;
      w_awvalidNxt  = 1'b0;
      w_wvalidNxt   = 1'b0;
      w_sRdataNxt   = ERR_DATA;
      w_sReadyNxt   = 1'b1;
      w_errValidNxt = 1'b1;
      w_errCodeNxt  = CODE_TIMEOUT;
      w_errAddrNxt  = r_addr;
      w_stateNxt    = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_arvalid  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_sReady   <= 1'b0;
      r_sRdata   <= '0;
      r_errValid <= 1'b0;
      r_errCode  <= 2'b00;
      r_errAddr  <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_stateNxt;
      r_addr     <= w_addrNxt;
      r_wdata    <= w_wdataNxt;
      r_wstrb    <= w_wstrbNxt;
      r_arvalid  <= w_arvalidNxt;
      r_awvalid  <= w_awvalidNxt;
      r_wvalid   <= w_wvalidNxt;
      r_sReady   <= w_sReadyNxt;
      r_sRdata   <= w_sRdataNxt;
      r_errValid <= w_errValidNxt;
      r_errCode  <= w_errCodeNxt;
      r_errAddr  <= w_errAddrNxt;
      r_count    <= w_countNxt;
    end
  end

  assign s_ready   = r_sReady;
  assign s_rdata   = r_sRdata;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_addr;
  assign m_arprot  = PROT;
  assign m_rready  = (r_state == RD_DATA);
  assign m_awvalid = r_awvalid;
  assign m_awaddr  = r_addr;
  assign m_awprot  = PROT;
  assign m_wvalid  = r_wvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_bready  = (r_state == WR_RESP);
  assign err_valid = r_errValid;
  assign err_code  = r_errCode;
  assign err_addr  = r_errAddr;

endmodule
